// File: rtl/dds_vhdl.sv
// Direct digital synthesiser: phase accumulator feeding a registered waveform
// generator. Define DDS_VHDL_SIGNED_OUT_EN for two's-complement signal_out.
module dds_vhdl #(
  parameter int phase_width = 4,
  parameter int data_width  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             control,
  input  logic [phase_width-1:0] phase_incr,
  output logic [phase_width-1:0] phase_out,
  output logic [data_width-1:0]  signal_out
);

  localparam logic [1:0] CTRL_SAW = 2'd0;
  localparam logic [1:0] CTRL_SQR = 2'd1;
  localparam logic [1:0] CTRL_TRI = 2'd2;
  localparam logic [1:0] CTRL_SIN = 2'd3;

  logic [phase_width-1:0] acc_q, acc_d;
  logic [data_width-1:0]  sig_q, sig_d;
  logic [data_width-1:0]  wave;
  logic [phase_width-2:0] tri_t;

  // One 16-entry quarter-symmetric sine period, offset binary.
  function automatic logic [7:0] sine_rom(input logic [3:0] idx);
    logic [7:0] val;
    case (idx)
      4'd0:    val = 8'd128;
      4'd1:    val = 8'd177;
      4'd2:    val = 8'd218;
      4'd3:    val = 8'd245;
      4'd4:    val = 8'd255;
      4'd5:    val = 8'd245;
      4'd6:    val = 8'd218;
      4'd7:    val = 8'd177;
      4'd8:    val = 8'd128;
      4'd9:    val = 8'd79;
      4'd10:   val = 8'd38;
      4'd11:   val = 8'd11;
      4'd12:   val = 8'd1;
      4'd13:   val = 8'd11;
      4'd14:   val = 8'd38;
      default: val = 8'd79;
    endcase
    return val;
  endfunction

  always_comb begin
    acc_d = acc_q + phase_incr;
    tri_t = acc_q[phase_width-1] ? ~acc_q[phase_width-2:0] : acc_q[phase_width-2:0];
    wave  = '0;
    // Samples are built from the pre-increment phase, so signal_out lags phase_out.
    case (control)
      CTRL_SAW: wave[data_width-1 -: phase_width] = acc_q;
      CTRL_SQR: wave = {data_width{~acc_q[phase_width-1]}};
      CTRL_TRI: wave[data_width-1 -: phase_width] = {tri_t, 1'b0};
      CTRL_SIN: wave[data_width-1 -: 8] = sine_rom(acc_q[3:0]);
      default:  wave = '0;
    endcase
    sig_d = wave;
`ifdef DDS_VHDL_SIGNED_OUT_EN
    sig_d[data_width-1] = ~wave[data_width-1];
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      sig_q <= '0;
    end else begin
      acc_q <= acc_d;
      sig_q <= sig_d;
    end
  end

  assign phase_out  = acc_q;
  assign signal_out = sig_q;

endmodule

// File: tb/tb_dds_vhdl.sv
// Randomised bench for dds_vhdl against an arithmetic waveform model.
module tb_dds_vhdl;

  logic       clk;
  logic       rst;
  logic [1:0] control;
  logic [3:0] phase_incr;
  logic [3:0] phase_out;
  logic [7:0] signal_out;

  int checks   = 0;
  int failures = 0;

  int model_acc = 0;
  logic [7:0] exp_q[$];
  int sine_tab[16] = '{128, 177, 218, 245, 255, 245, 218, 177,
                       128, 79, 38, 11, 1, 11, 38, 79};

  dds_vhdl #(.phase_width(4), .data_width(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .control    (control),
    .phase_incr (phase_incr),
    .phase_out  (phase_out),
    .signal_out (signal_out)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog obs=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // Waveform value from the shape definitions, in plain arithmetic.
  function automatic logic [7:0] ref_wave(input int c, input int a);
    int v;
    case (c)
      0:       v = a * 16;
      1:       v = (a < 8) ? 255 : 0;
      2:       v = (a < 8) ? a * 32 : (15 - a) * 32;
      default: v = sine_tab[a];
    endcase
`ifdef DDS_VHDL_SIGNED_OUT_EN
    v = v ^ 128;
`endif
    return v[7:0];
  endfunction

  // Drive one cycle's inputs, advance the model, check after the edge.
  task automatic step(input string tag, input int c, input int incr);
    control    = c[1:0];
    phase_incr = incr[3:0];
    exp_q.push_back(ref_wave(c, model_acc));
    model_acc = (model_acc + incr) % 16;
    @(posedge clk);
    #1;
    check_eq({tag, "_phase"}, phase_out, model_acc);
    check_eq({tag, "_signal"}, signal_out, exp_q.pop_front());
  endtask

  // Assert reset between edges, check the outputs clear without a clock.
  task automatic async_reset(input int hold_cycles);
    #2;
    rst = 1'b0;
    #1;
    check_eq("rst_now_phase", phase_out, 0);
    check_eq("rst_now_signal", signal_out, 0);
    model_acc = 0;
    exp_q.delete();
    for (int i = 0; i < hold_cycles; i++) begin
      @(posedge clk);
      #1;
      check_eq("rst_hold_phase", phase_out, 0);
      check_eq("rst_hold_signal", signal_out, 0);
    end
    rst = 1'b1;
  endtask

  initial begin
    rst        = 1'b0;
    control    = 2'd0;
    phase_incr = 4'd1;
    #1;
    check_eq("reset_phase", phase_out, 0);
    check_eq("reset_signal", signal_out, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("reset_held_phase", phase_out, 0);
      check_eq("reset_held_signal", signal_out, 0);
    end
    rst = 1'b1;

    // Phase walks 1..15,0,1 with sawtooth
    for (int i = 0; i < 17; i++) step("saw_inc1", 0, 1);

    // Sine from a fresh reset
    async_reset(1);
    for (int i = 0; i < 17; i++) step("sine", 3, 1);

    // Triangle then square over full periods
    for (int i = 0; i < 16; i++) step("tri", 2, 1);
    for (int i = 0; i < 16; i++) step("square", 1, 1);

    // Sawtooth at double rate, including wrap 14+2 -> 0
    for (int i = 0; i < 16; i++) step("saw_inc2", 0, 2);

    // Hold phase with zero increment
    for (int i = 0; i < 4; i++) step("hold", 3, 0);

    // Mid-stream reset and restart
    async_reset(2);
    step("restart", 2, 5);
    step("restart2", 3, 7);

    // Randomised control/increment, with occasional reset
    for (int i = 0; i < 300; i++) begin
      int c;
      int incr;
      c    = $urandom_range(0, 3);
      incr = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 15);
      step("rand", c, incr);
      if ($urandom_range(0, 49) == 0) async_reset($urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dds_vhdl.md
DDS_VHDL -- requirements
Module: dds_vhdl

Interface
REQ-001 Parameter phase_width, default 4, is the width of the phase accumulator, phase_incr and phase_out; only 4 is supported.
REQ-002 Parameter data_width, default 8, is the sample width of signal_out; legal values are 8 or more.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  is the asynchronous, active-low reset.
REQ-005 Port control  input  2  selects the waveform: 0 sawtooth, 1 square, 2 triangle, 3 sine.
REQ-006 Port phase_incr  input  phase_width  is the unsigned phase step added each clock.
REQ-007 Port phase_out  output  phase_width  is the current accumulator value, driven directly from the register.
REQ-008 Port signal_out  output  data_width  is the registered waveform sample in offset-binary (unsigned) format.

Function
REQ-009 On each rising clk edge with rst high, the accumulator SHALL load acc + phase_incr, modulo 2^phase_width (e.g. 15+1 -> 0, 14+2 -> 0).
REQ-010 phase_incr = 0 SHALL hold the phase; signal_out then remains constant for a constant control.
REQ-011 On the same edge, signal_out SHALL load f(control, acc) using the pre-increment acc, giving one cycle of latency relative to phase_out.
REQ-012 Sawtooth (control 0): acc placed in the MSBs with zero fill below; for width 4/8 this gives 0,16,32,...,240.
REQ-013 Square (control 1): all ones when acc MSB = 0, else all zeros.
REQ-014 Triangle (control 2): t = acc[pw-2:0] when MSB = 0, else its bitwise inverse; output is {t,1'b0} MSB-aligned with zero fill; for width 4/8 this gives 0,32,...,224,224,192,...,0.
REQ-015 Sine (control 3): 16-entry internal ROM indexed by acc, 8-bit values 128,177,218,245,255,245,218,177,128,79,38,11,1,11,38,79; for data_width > 8 the value is MSB-aligned with zero fill.
REQ-016 A control change SHALL take effect on the next signal_out update, without disturbing the accumulator.
REQ-017 A phase_incr change SHALL take effect on the next edge.
REQ-018 There SHALL be no other state; no output is combinationally dependent on control or phase_incr.

Reset
REQ-019 Asserting rst low SHALL immediately, with no clock required, force acc/phase_out = 0 and signal_out = 0, including mid-operation.
REQ-020 On the first rising edge after rst goes high, phase_out SHALL become phase_incr and signal_out SHALL become f(control, 0).

Configuration
REQ-021 Macro DDS_VHDL_SIGNED_OUT_EN: when defined, signal_out SHALL be two's complement, i.e. the offset-binary value with its MSB inverted; reset value remains 0.
REQ-022 Without DDS_VHDL_SIGNED_OUT_EN, signal_out SHALL be offset binary exactly as in REQ-012 to REQ-015.

Verification (phase_width 4, data_width 8, macro undefined unless stated)
REQ-023 Hold rst low, then release with incr = 1 -> outputs are 0 while held; phase_out then steps 1,2,...,15,0,1.
REQ-024 control 3, incr 1, after reset -> signal_out sequence 128,177,218,245,255,245,...,79,128, lagging phase_out by one cycle.
REQ-025 control 2 then control 1, incr 1 -> triangle 0,32,...,224,224,...,0; then square is 255 for acc 0-7 and 0 for acc 8-15.
REQ-026 control 0, incr 2 -> phase_out steps 2,4,...,14,0; sawtooth values 0,32,...,224 repeat.
REQ-027 Drop rst low mid-stream, between clock edges -> phase_out and signal_out are 0 at once; after release, the sequence restarts from REQ-020.
REQ-028 DDS_VHDL_SIGNED_OUT_EN defined, control 3 -> acc 0 gives 0x00, acc 4 gives 0x7F, acc 12 gives 0x81.
